// File: rtl/mips32_pkg.sv
// Shared MIPS32 opcode constants, instruction classes and
// fetch-queue types used across the pipeline.
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    IT_RR_ALU,
    IT_RM_ALU,
    IT_LOAD,
    IT_STORE,
    IT_BRANCH,
    IT_HALT,
    IT_ILLEGAL
  } itype_e;

  typedef enum logic {
    FQ_FETCH   = 1'b0,
    FQ_STOPPED = 1'b1
  } fq_state_e;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } fq_entry_t;

  function automatic logic is_hlt(input logic [31:0] ir);
    return ir[31:26] == OP_HLT;
  endfunction

  function automatic itype_e instr_type(input logic [31:0] ir);
    itype_e t;
    t = IT_ILLEGAL;
    case (ir[31:26])
      OP_ADD, OP_SUB, OP_AND,
      OP_OR, OP_SLT, OP_MUL:     t = IT_RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI: t = IT_RM_ALU;
      OP_LW:                     t = IT_LOAD;
      OP_SW:                     t = IT_STORE;
      OP_BNEQZ, OP_BEQZ:         t = IT_BRANCH;
      OP_HLT:                    t = IT_HALT;
      default:                   t = IT_ILLEGAL;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mips32_sync_fifo.sv
// Circular instruction buffer: storage, head/tail pointers
// and occupancy count, with a single-cycle flush.
module mips32_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_flush,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_wdata,
  input  logic                    i_pop,
  output logic [WIDTH-1:0]        o_rdata,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW:0]      r_count;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign w_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign w_push  = i_push && !i_flush && (!w_full || w_pop);
  assign o_rdata = r_mem[r_head];
  assign o_count = r_count;

  // Storage write at the tail; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_wdata;
  end

  // Pointer and count update; flush wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + (PW+1)'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - (PW+1)'(1);
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(i_push && !i_flush && w_full && !w_pop)
  );

endmodule

// File: rtl/mips32_fetch_queue.sv
// Instruction fetch unit: PC, request throttling, redirect
// flush and HLT stop, feeding a small instruction queue.
module mips32_fetch_queue
  import mips32_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 10,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk1,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_valid,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          out_valid,
  output logic [31:0]   out_ir,
  output logic [31:0]   out_npc,
  input  logic          out_ready,
  output logic          fetch_stopped
);

  localparam int CW = $clog2(DEPTH) + 1;

  fq_state_e    r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_req_pc;
  logic         r_inflight;

  logic [CW-1:0] w_count;
  logic [CW-1:0] w_occ;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_hlt_in;
  fq_entry_t     w_wentry;
  fq_entry_t     w_head;

  // A response only counts if we actually asked for it last
  // cycle; stale data after reset or redirect is dropped.
  assign w_push   = imem_valid && r_inflight && !redirect;
  assign w_hlt_in = w_push && is_hlt(imem_rdata);
  assign w_occ    = w_count + CW'(r_inflight);
  assign w_pop    = out_valid && out_ready && !redirect;

  assign imem_req = !rst && !redirect
                 && (r_state == FQ_FETCH)
                 && !w_hlt_in
                 && (w_occ < CW'(DEPTH));

  assign imem_addr     = r_pc[AW-1:0];
  assign fetch_stopped = (r_state == FQ_STOPPED);

  assign w_wentry.ir  = imem_rdata;
  assign w_wentry.npc = r_req_pc + 32'd1;

  assign out_valid = !w_empty;
  assign out_ir    = w_head.ir;
  assign out_npc   = w_head.npc;

  // PC, in-flight tag and FETCH/STOPPED state; redirect wins.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
      r_state    <= FQ_FETCH;
    end else begin
      r_inflight <= imem_req;
      if (imem_req) r_req_pc <= r_pc;
      if (redirect) begin
        r_pc    <= redirect_pc;
        r_state <= FQ_FETCH;
      end else begin
        if (imem_req) r_pc <= r_pc + 32'd1;
        if (w_hlt_in) r_state <= FQ_STOPPED;
      end
    end
  end

  mips32_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk     (clk1),
    .rst     (rst),
    .i_flush (redirect),
    .i_push  (w_push),
    .i_wdata (w_wentry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Bench for mips32_fetch_queue: queue-based reference model
// checked every cycle, plus directed literal expectations.
module tb_mips32_fetch_queue;

  localparam int          DEPTH = 4;
  localparam int          AW    = 10;
  localparam logic [31:0] RPC   = 32'h0;

  logic          clk1 = 1'b0;
  logic          rst = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          imem_valid = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          out_valid;
  logic [31:0]   out_ir;
  logic [31:0]   out_npc;
  logic          out_ready = 1'b0;
  logic          fetch_stopped;

  always #5 clk1 = ~clk1;

  mips32_fetch_queue #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .RESET_PC (RPC)
  ) dut (
    .clk1          (clk1),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ir        (out_ir),
    .out_npc       (out_npc),
    .out_ready     (out_ready),
    .fetch_stopped (fetch_stopped)
  );

  logic [31:0] mem [1024];
  int nerr = 0;
  int nchk = 0;

  logic [63:0] mq [$];
  logic [31:0] mpc = '0;
  logic        minfl = 1'b0;
  logic [31:0] minfl_pc = '0;
  logic        mstop = 1'b0;

  logic        resp_v = 1'b0;
  logic [31:0] resp_d = '0;
  logic        inj_v = 1'b0;
  logic [31:0] inj_d = '0;

  logic          s_req, s_ov, s_stop;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_ir, s_npc;
  logic [31:0]   pop_npc [$];
  logic [31:0]   pop_ir [$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc = RPC;
    minfl = 1'b0;
    minfl_pc = '0;
    mstop = 1'b0;
    resp_v = 1'b0;
  endtask

  // One clock cycle: drive memory response, compare, advance model.
  task automatic cyc();
    logic push, hlt, ereq, eov;
    int n;
    imem_valid = resp_v | inj_v;
    imem_rdata = inj_v ? inj_d : resp_d;
    #1;
    n    = mq.size();
    push = imem_valid && minfl && !redirect;
    hlt  = push && (imem_rdata[31:26] == 6'h3f);
    ereq = !redirect && !mstop && !hlt && ((n + int'(minfl)) < DEPTH);
    eov  = (n != 0);
    chk("req", imem_req, ereq);
    chk("stopped", fetch_stopped, mstop);
    chk("out_valid", out_valid, eov);
    if (ereq) chk("addr", 32'(imem_addr), 32'(mpc[AW-1:0]));
    if (eov) begin
      chk("out_ir", out_ir, mq[0][63:32]);
      chk("out_npc", out_npc, mq[0][31:0]);
    end
    s_req = imem_req; s_addr = imem_addr; s_ov = out_valid;
    s_ir = out_ir; s_npc = out_npc; s_stop = fetch_stopped;
    if (out_valid && out_ready && !redirect) begin
      pop_npc.push_back(out_npc);
      pop_ir.push_back(out_ir);
    end
    resp_v = imem_req;
    resp_d = mem[imem_addr];
    if (redirect) begin
      mq.delete();
      mpc = redirect_pc;
      mstop = 1'b0;
      minfl = 1'b0;
    end else begin
      if (eov && out_ready) void'(mq.pop_front());
      if (push) mq.push_back({imem_rdata, minfl_pc + 32'd1});
      if (hlt) mstop = 1'b1;
      minfl = ereq;
      if (ereq) begin
        minfl_pc = mpc;
        mpc = mpc + 32'd1;
      end
    end
    @(posedge clk1);
    @(negedge clk1);
    inj_v = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_valid = 1'b0;
    redirect = 1'b0;
    inj_v = 1'b0;
    @(negedge clk1);
    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_stop", fetch_stopped, 0);
    @(negedge clk1);
    rst = 1'b0;
    model_reset();
    pop_npc.delete();
    pop_ir.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end

  initial begin
    int maxa;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0100_0000 | 32'(i);
    #1 rst = 1'b1;

    // streaming: one request and one pop per cycle
    out_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (c == 0) begin
        chk("t2_req0", s_req, 1);
        chk("t2_addr0", 32'(s_addr), 0);
        chk("t2_ov0", s_ov, 0);
      end
      if (c == 1) begin
        chk("t2_addr1", 32'(s_addr), 1);
        chk("t2_ov1", s_ov, 0);
      end
      if (c == 2) begin
        chk("t2_ov2", s_ov, 1);
        chk("t2_npc2", s_npc, 32'h1);
        chk("t2_ir2", s_ir, 32'h0100_0000);
      end
      if (c == 3) chk("t2_npc3", s_npc, 32'h2);
    end
    chk("t2_pops", pop_npc.size(), 10);

    // backpressure then drain
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) cyc();
    chk("t3_req_sat", s_req, 0);
    chk("t3_ov_sat", s_ov, 1);
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) cyc();
    foreach (pop_npc[i]) begin
      chk("t3_seq_npc", pop_npc[i], 32'(i + 1));
      chk("t3_seq_ir", pop_ir[i], 32'h0100_0000 | 32'(i));
    end

    // redirect while full with a stray response
    out_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 8; c++) cyc();
    chk("t4_full_req", s_req, 0);
    out_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    inj_v = 1'b1;
    inj_d = 32'hDEAD_BEEF;
    cyc();
    redirect = 1'b0;
    cyc();
    chk("t4_ov_after", s_ov, 0);
    chk("t4_req_after", s_req, 1);
    chk("t4_addr_after", 32'(s_addr), 32'h40);
    cyc();
    chk("t4_ov_lat", s_ov, 0);
    cyc();
    chk("t4_ov_first", s_ov, 1);
    chk("t4_npc_first", s_npc, 32'h41);
    chk("t4_ir_first", s_ir, 32'h0100_0040);

    // HLT at address 3 stops fetching, queue drains
    mem[3] = 32'hFC00_0000;
    out_ready = 1'b1;
    do_reset();
    maxa = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (s_req && int'(s_addr) > maxa) maxa = int'(s_addr);
    end
    chk("t5_maxaddr", 32'(maxa), 3);
    chk("t5_stop", s_stop, 1);
    chk("t5_pops", pop_npc.size(), 4);
    if (pop_ir.size() == 4) chk("t5_hlt_ir", pop_ir[3], 32'hFC00_0000);
    redirect = 1'b1;
    redirect_pc = 32'h0;
    cyc();
    redirect = 1'b0;
    cyc();
    chk("t5_resume_req", s_req, 1);
    chk("t5_resume_addr", 32'(s_addr), 0);
    chk("t5_resume_stop", s_stop, 0);
    mem[3] = 32'h0100_0003;

    // asynchronous reset with three entries queued
    out_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 4; c++) cyc();
    imem_valid = resp_v;
    imem_rdata = resp_d;
    #1 chk("t6_ov_pre", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_ov_async", out_valid, 0);
    chk("t6_req_async", imem_req, 0);
    @(negedge clk1);
    rst = 1'b0;
    model_reset();
    inj_v = 1'b1;
    inj_d = 32'hFC00_0000;
    cyc();
    chk("t6_req_first", s_req, 1);
    chk("t6_addr_first", 32'(s_addr), 32'(RPC[AW-1:0]));
    chk("t6_ov_first", s_ov, 0);
    cyc();
    chk("t6_ov_stale", s_ov, 0);
    chk("t6_stop_stale", s_stop, 0);
    cyc();
    chk("t6_ov_real", s_ov, 1);
    chk("t6_npc_real", s_npc, 32'h1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
